// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package disp_pkg;

  localparam logic [0:6] SEG_OFF = 7'b1111111;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// Dwell counter for the scan FSM: counts up to a runtime-selected terminal value.
module scan_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic [CNT_W-1:0] last,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == last);

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans a frame of nibbles across common-anode digits through one external hex decoder,
// with an all-off gap before each digit and frame updates only at frame boundaries.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   load_blank,
  output logic [3:0]              nibble_out,
  input  logic [0:6]              seg_in,
  output logic [0:6]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_n,
  output logic                    frame_tick
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  scan_state_e      state_p0, state_nxt;
  logic [IDX_W-1:0] idx_p0, idx_nxt;
  logic             boundary;
  logic             timer_done;
  logic [CNT_W-1:0] timer_last;

  logic [4*NUM_DIGITS-1:0] active_data, pend_data;
  logic [NUM_DIGITS-1:0]   active_blank, pend_blank;
  logic                    pend_full;
  logic                    accept;

  logic             show_p1;
  logic [IDX_W-1:0] idx_p1;

  assign timer_last = (state_p0 == SHOW) ? SHOW_LAST : GAP_LAST;

  scan_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clock(clock),
    .reset(reset),
    .clear(timer_done),
    .last (timer_last),
    .done (timer_done)
  );

  // Stage 0: scan state, digit index and frame buffers
  always_comb begin
    state_nxt = state_p0;
    idx_nxt   = idx_p0;
    boundary  = 1'b0;
    case (state_p0)
      GAP: begin
        if (timer_done) state_nxt = SHOW;
      end
      SHOW: begin
        if (timer_done) begin
          state_nxt = GAP;
          if (idx_p0 == LAST_IDX) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx_p0 + 1'b1;
          end
        end
      end
      default: state_nxt = GAP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= GAP;
      idx_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      idx_p0   <= idx_nxt;
    end
  end

  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;

  // A boundary swap and an accept can never coincide: accept needs pend_full low.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_full    <= 1'b0;
      active_data  <= '0;
      active_blank <= '1;
    end else begin
      if (boundary && pend_full) begin
        active_data  <= pend_data;
        active_blank <= pend_blank;
        pend_full    <= 1'b0;
      end
      if (accept) begin
        pend_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      pend_data  <= load_data;
      pend_blank <= load_blank;
    end
  end

  // Stage 1: decoder input and lit qualifier
  always_ff @(posedge clock) begin
    if (reset) begin
      nibble_out <= 4'h0;
      show_p1    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      nibble_out <= (state_p0 == SHOW) ? active_data[{idx_p0, 2'b00} +: 4] : 4'h0;
      show_p1    <= (state_p0 == SHOW) && !active_blank[idx_p0];
      frame_tick <= boundary;
    end
  end

  always_ff @(posedge clock) begin
    idx_p1 <= idx_p0;
  end

  // Stage 2: pins; segments and anode switch on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_out <= SEG_OFF;
      digit_n <= '1;
    end else begin
      seg_out <= show_p1 ? seg_in : SEG_OFF;
      digit_n <= show_p1 ? ~(NUM_DIGITS'(1) << idx_p1) : '1;
    end
  end

endmodule
